// File: rtl/ask_uart_frame_deframer.sv
// Link-layer deframer for the ASK UART receive path: hunts preamble+sync, extracts
// length-delimited payloads, checks the XOR checksum and emits AXI-Stream packets.
module ask_uart_frame_deframer #(
    parameter logic [7:0] PREAMBLE_BYTE  = 8'h55,
    parameter int         PREAMBLE_COUNT = 3,
    parameter logic [7:0] SYNC_BYTE      = 8'hD3,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT        = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    output logic       i_tready,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       o_tready,
    output logic       o_tlast,
    output logic       o_tuser,
    output logic       frame_ok,
    output logic       frame_err
);
    localparam int PC_W = $clog2(PREAMBLE_COUNT + 1);
    localparam int TM_W = $clog2(TIMEOUT + 1);
    localparam logic [PC_W-1:0] PC_LAST   = PC_W'(PREAMBLE_COUNT - 1);
    localparam logic [TM_W-1:0] TM_LAST   = TM_W'(TIMEOUT - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {HUNT, SYNC, LEN, PAYLOAD, CSUM, ABORT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pre_cnt;
    logic [7:0]      remaining;
    logic [7:0]      csum;
    logic [7:0]      hold_data;
    logic            hold_valid;
    logic [TM_W-1:0] tmo_cnt;

    logic accept, out_free, in_frame, tmo_hit, hunt_done;
    logic emit, emit_last, emit_user, ok_nxt, err_nxt;

    assign i_tready  = ~o_tvalid | o_tready;
    assign out_free  = i_tready;
    assign accept    = i_tvalid & i_tready;
    assign in_frame  = (state == SYNC) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    assign tmo_hit   = in_frame & ~accept & (tmo_cnt == TM_LAST);
    assign hunt_done = accept & (i_tdata == PREAMBLE_BYTE) & (pre_cnt == PC_LAST);

    always_ff @(posedge clk) begin
        if (!rst) state <= HUNT;
        else      state <= state_nxt;
    end

    // Bytes are delayed one slot in the hold register so tlast/tuser can ride on the final byte.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_user = 1'b0;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            HUNT: begin
                if (hunt_done) state_nxt = SYNC;
            end
            SYNC: begin
                if (accept && i_tdata != PREAMBLE_BYTE)
                    state_nxt = (i_tdata == SYNC_BYTE) ? LEN : HUNT;
            end
            LEN: begin
                if (accept) begin
                    if (i_tdata == 8'd0 || i_tdata > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    emit = hold_valid;
                    if (remaining == 8'd1) state_nxt = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_user = (i_tdata != csum);
                    ok_nxt    = (i_tdata == csum);
                    err_nxt   = (i_tdata != csum);
                    state_nxt = HUNT;
                end
            end
            ABORT: begin
                // A byte accepted on the flush cycle is already part of the next hunt.
                if (out_free) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_user = 1'b1;
                    state_nxt = hunt_done ? SYNC : HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase

        if (tmo_hit) begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
            if (hold_valid) begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_user = 1'b1;
                end else begin
                    state_nxt = ABORT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt    <= '0;
            remaining  <= '0;
            csum       <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            tmo_cnt    <= '0;
            o_tdata    <= '0;
            o_tvalid   <= 1'b0;
            o_tlast    <= 1'b0;
            o_tuser    <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;

            if (emit) begin
                o_tdata  <= hold_data;
                o_tvalid <= 1'b1;
                o_tlast  <= emit_last;
                o_tuser  <= emit_user;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
                o_tuser  <= 1'b0;
            end

            if (accept && (state == HUNT || state == ABORT))
                pre_cnt <= (i_tdata == PREAMBLE_BYTE && pre_cnt != PC_LAST) ? pre_cnt + PC_W'(1) : '0;
            else if (state != HUNT)
                pre_cnt <= '0;

            if (accept && state == LEN) begin
                remaining <= i_tdata;
                csum      <= i_tdata;
            end else if (accept && state == PAYLOAD) begin
                remaining <= remaining - 8'd1;
                csum      <= csum ^ i_tdata;
            end

            if (accept && state == PAYLOAD) begin
                hold_data  <= i_tdata;
                hold_valid <= 1'b1;
            end else if (emit_last) begin
                hold_valid <= 1'b0;
            end

            if (!in_frame || accept || tmo_hit) tmo_cnt <= '0;
            else                                tmo_cnt <= tmo_cnt + TM_W'(1);
        end
    end

endmodule

// File: doc/ask_uart_frame_deframer.md
Name: ask_uart_frame_deframer

Overview:
- Byte-level link-layer receiver downstream of the ASK UART RX path (ASK detector -> axis UART RX wrapper -> this block).
- Hunts for a preamble/sync header in the raw received byte stream, extracts length-delimited payloads and checks an XOR checksum.
- Emits each payload as an AXI-Stream packet with tlast and an error tuser bit.
- Gives the ASK link framed packets instead of free-running bytes.

Parameters:
- PREAMBLE_BYTE, 8'h55, value of each preamble byte.
- PREAMBLE_COUNT, 3, minimum consecutive preamble bytes before sync is accepted (1..15).
- SYNC_BYTE, 8'hD3, sync byte that follows the preamble.
- MAX_LEN, 64, largest legal payload length (1..255).
- TIMEOUT, 4096, maximum clk cycles between accepted bytes inside a frame.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_tdata  in  8  received byte from UART RX
- i_tvalid  in  1  input byte valid
- i_tready  out  1  input ready
- o_tdata  out  8  payload byte
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- o_tlast  out  1  last payload byte of frame
- o_tuser  out  1  valid with o_tlast: 1 = frame bad (checksum mismatch or timeout)
- frame_ok  out  1  one-cycle pulse: frame finished with good checksum
- frame_err  out  1  one-cycle pulse: bad length, bad checksum or timeout

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=HUNT; all counters, hold register and checksum cleared.
  - o_tvalid, o_tlast, o_tuser, frame_ok, frame_err all 0; o_tdata 0.
  - Reset mid-frame discards the frame with no tlast emitted.
- Handshake:
  - Input beat accepted when i_tvalid & i_tready.
  - i_tready = ~o_tvalid | o_tready, in every state.
  - Output register holds data until o_tvalid & o_tready; no byte is ever dropped or duplicated.
- States:
  - HUNT: count consecutive PREAMBLE_BYTE beats. A non-preamble byte clears the count. When count reaches PREAMBLE_COUNT, go to SYNC.
  - SYNC: further PREAMBLE_BYTE stays in SYNC. SYNC_BYTE goes to LEN. Any other byte goes to HUNT with count=0.
  - LEN: if byte==0 or byte>MAX_LEN, pulse frame_err and go to HUNT. Otherwise remaining=byte, csum=byte, go to PAYLOAD.
  - PAYLOAD: for each accepted byte, csum^=byte and remaining-=1.
    - Byte goes to the hold register; any previously held byte moves to the output register with tlast=0.
    - When remaining reaches 0, go to CSUM.
  - CSUM: on the accepted byte, move the held byte to the output with tlast=1 and tuser=(byte!=csum).
    - Pulse frame_ok or frame_err in the same cycle, then go to HUNT.
- Latency: payload byte n appears on o_tdata the cycle after byte n+1 (or the checksum byte) is accepted. This one-byte delay lets tlast/tuser ride on the final byte.
- Timeout:
  - Counter increments each cycle with no accepted beat in SYNC, LEN, PAYLOAD or CSUM; reset on every accepted beat; frozen and cleared in HUNT.
  - Timeout fires when the counter reaches TIMEOUT-1, then go to HUNT and pulse frame_err.
  - If the hold register is valid, its byte is emitted with tlast=1, tuser=1. If the output register is still occupied, the emit waits; state stays in an ABORT state until it is emitted.
  - If the hold register is empty, there is no output.
- Back-to-back frames: a new preamble may start the cycle after CSUM; HUNT counting restarts from 0.
- Simultaneous events: an accepted beat in the same cycle as timeout expiry wins and clears the timer.
- Widths:
  - Preamble counter $clog2(PREAMBLE_COUNT+1).
  - remaining 8 bits.
  - Timeout counter $clog2(TIMEOUT+1).

Test Plan:
- Good frame: 55 55 55 D3 03 A1 B2 C3 D3 -> output A1, B2, C3 (tlast on C3, tuser=0); frame_ok pulses once; no frame_err.
- Bad checksum: same frame ending with 00 -> A1, B2, C3 with tlast=1, tuser=1 on C3; frame_err pulses; next good frame is received normally.
- Header rejection:
  - 55 55 D3 03 ... (only 2 preambles) -> no output.
  - 55 55 55 D3 00 -> frame_err, no output.
  - 55 55 55 D3 41 (65 > MAX_LEN) -> frame_err, no output.
- Backpressure: good frame with o_tready toggling 1-in-3 -> i_tready deasserts whenever output is stalled; all 3 bytes delivered in order exactly once.
- Timeout: 55 55 55 D3 03 A1 B2, then idle 4096 cycles -> A1 (tlast=0), B2 (tlast=1, tuser=1); frame_err pulses; state back to HUNT.
- Reset mid-payload: rst=0 after byte B2 -> all outputs 0 the next cycle, no tlast; subsequent good frame decodes correctly.
